fb_plot_sink: RTL

Receiving end of the pixel-plot interface (vga_x/vga_y/vga_colour/vga_plot) that the circle and fill engines drive. It stores every accepted plot in an on-chip 160x120x3 framebuffer and provides a 1-cycle-latency read port, so benches and a later scan-out stage can read back what was drawn. It also provides a hardware clear sweep, plus plot, out-of-bounds and dropped-plot counters for self-checking.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_ram.sv | 28 ++
 rtl/fb_plot_sink.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared constants, types and address helper for the pixel-plot framebuffer sink.
package fb_pkg;

   localparam int unsigned FB_W      = 160;
   localparam int unsigned FB_H      = 120;
   localparam int unsigned FB_DEPTH  = 19200;
   localparam int unsigned FB_ADDR_W = 15;

   typedef enum logic {
      FB_IDLE  = 1'b0,
      FB_CLEAR = 1'b1
   } fb_state_e;

   typedef logic [2:0] colour_t;

   // y*160 + x built from shifts so no multiplier is inferred.
   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
      logic [FB_ADDR_W-1:0] yw;
      logic [FB_ADDR_W-1:0] xw;
      yw = {8'b0, y};
      xw = {7'b0, x};
      return (yw << 7) + (yw << 5) + xw;
   endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module fb_ram #(
   parameter int unsigned Depth = 19200,
   parameter int unsigned AddrW = 15,
   parameter int unsigned DataW = 3
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/fb_plot_sink.sv
// Pixel-plot receiver: stores plots in a 160x120x3 framebuffer, offers a 1-cycle read port,
// a hardware clear sweep and saturating plot / out-of-bounds / dropped-plot counters.
module fb_plot_sink
   import fb_pkg::*;
#(
   parameter int unsigned COLOUR_W = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          vga_x,
   input  logic [6:0]          vga_y,
   input  logic [COLOUR_W-1:0] vga_colour,
   input  logic                vga_plot,
   input  logic                clear_req,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                busy,
   input  logic                rd_en,
   input  logic [7:0]          rd_x,
   input  logic [6:0]          rd_y,
   output logic                rd_valid,
   output logic [COLOUR_W-1:0] rd_colour,
   output logic [CNT_W-1:0]    plot_count,
   output logic [CNT_W-1:0]    oob_count,
   output logic [CNT_W-1:0]    drop_count
);

   localparam logic [FB_ADDR_W-1:0] LastAddr = FB_ADDR_W'(FB_DEPTH - 1);

   fb_state_e             state_q, state_d;
   logic [FB_ADDR_W-1:0]  clr_addr_q, clr_addr_d;
   logic [COLOUR_W-1:0]   clr_col_q, clr_col_d;
   logic [CNT_W-1:0]      plot_cnt_q, plot_cnt_d;
   logic [CNT_W-1:0]      oob_cnt_q, oob_cnt_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
   logic                  rd_valid_q, rd_oob_q;
   logic [COLOUR_W-1:0]   rd_last_q;

   logic                  plot_inb, rd_inb, clear_acc;
   logic                  ram_we;
   logic [FB_ADDR_W-1:0]  ram_waddr;
   logic [COLOUR_W-1:0]   ram_wdata;
   logic [COLOUR_W-1:0]   ram_rdata;

   assign plot_inb  = (32'(vga_x) < FB_W) && (32'(vga_y) < FB_H);
   assign rd_inb    = (32'(rd_x) < FB_W) && (32'(rd_y) < FB_H);
   assign clear_acc = (state_q == FB_IDLE) && clear_req;

   // Clear sweep owns the write port; a plot coinciding with an accepted clear is dropped.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = fb_addr(vga_x, vga_y);
      ram_wdata = vga_colour;
      if (state_q == FB_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr_q;
         ram_wdata = clr_col_q;
      end else if (vga_plot && plot_inb && !clear_req) begin
         ram_we = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_col_d  = clr_col_q;
      plot_cnt_d = plot_cnt_q;
      oob_cnt_d  = oob_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (state_q == FB_CLEAR) begin
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == LastAddr) begin
            state_d = FB_IDLE;
         end
         if (vga_plot && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end else if (clear_acc) begin
         state_d    = FB_CLEAR;
         clr_addr_d = '0;
         clr_col_d  = clear_colour;
         plot_cnt_d = '0;
         oob_cnt_d  = '0;
         if (vga_plot && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end else if (vga_plot) begin
         if (plot_inb) begin
            if (plot_cnt_q != '1) plot_cnt_d = plot_cnt_q + 1'b1;
         end else begin
            if (oob_cnt_q != '1) oob_cnt_d = oob_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FB_CLEAR;
         clr_addr_q <= '0;
         clr_col_q  <= '0;
         plot_cnt_q <= '0;
         oob_cnt_q  <= '0;
         drop_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
         rd_last_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         clr_col_q  <= clr_col_d;
         plot_cnt_q <= plot_cnt_d;
         oob_cnt_q  <= oob_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         rd_valid_q <= rd_en;
         rd_oob_q   <= rd_en && !rd_inb;
         if (rd_valid_q) begin
            rd_last_q <= rd_colour;
         end
      end
   end

   fb_ram #(
      .Depth (FB_DEPTH),
      .AddrW (FB_ADDR_W),
      .DataW (COLOUR_W)
   ) u_fb_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (rd_en && rd_inb),
      .raddr_i (fb_addr(rd_x, rd_y)),
      .rdata_o (ram_rdata)
   );

   // RAM output register has no reset, so the held value lives in rd_last_q.
   always_comb begin
      rd_colour = rd_last_q;
      if (rd_valid_q) begin
         rd_colour = rd_oob_q ? '0 : ram_rdata;
      end
   end

   assign busy       = (state_q == FB_CLEAR);
   assign rd_valid   = rd_valid_q;
   assign plot_count = plot_cnt_q;
   assign oob_count  = oob_cnt_q;
   assign drop_count = drop_cnt_q;

endmodule
